// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings,
// MMIO register offsets, STATUS bit positions and lane helper functions.
package dmem_pkg;

    // Access size encodings on the core's select bus (one-hot).
    localparam logic [2:0] SEL_BYTE = 3'b001;
    localparam logic [2:0] SEL_HALF = 3'b010;
    localparam logic [2:0] SEL_WORD = 3'b100;

    // Byte offsets of the MMIO registers inside the MMIO window.
    localparam logic [4:0] OFF_TX     = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_CYCLE  = 5'h08;
    localparam logic [4:0] OFF_LOADS  = 5'h0C;
    localparam logic [4:0] OFF_STORES = 5'h10;

    // STATUS register bit positions.
    localparam int unsigned ST_EMPTY = 32'd0;
    localparam int unsigned ST_FULL  = 32'd1;
    localparam int unsigned ST_OVF   = 32'd2;
    localparam int unsigned ST_ERR   = 32'd3;

    // Decoded MMIO register target.
    typedef enum logic [2:0] {
        REG_TX     = 3'd0,
        REG_STATUS = 3'd1,
        REG_CYCLE  = 3'd2,
        REG_LOADS  = 3'd3,
        REG_STORES = 3'd4,
        REG_NONE   = 3'd7
    } mmio_reg_e;

    // True when the size code is one of the three legal one-hot values.
    function automatic logic sel_onehot(input logic [2:0] sel);
        logic ok;
        case (sel)
            SEL_BYTE, SEL_HALF, SEL_WORD: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when a half or word access is not naturally aligned.
    function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] off);
        logic m;
        case (sel)
            SEL_HALF: m = off[0];
            SEL_WORD: m = (off != 2'b00);
            default:  m = 1'b0;
        endcase
        return m;
    endfunction

    // Moves the addressed big-endian lane(s) to the top of the load word.
    function automatic logic [31:0] load_lanes(input logic [31:0] word,
                                               input logic [2:0]  sel,
                                               input logic [1:0]  off);
        logic [31:0] r;
        case (sel)
            SEL_BYTE: r = word << {off, 3'b000};
            SEL_HALF: r = word << {off[1], 4'b0000};
            default:  r = word;
        endcase
        return r;
    endfunction

    // Per-lane write enables; bit 3 is word bits [31:24] (byte offset 0).
    function automatic logic [3:0] byte_enables(input logic [2:0] sel,
                                                input logic [1:0] off);
        logic [3:0] be;
        case (sel)
            SEL_BYTE: be = 4'b1000 >> off;
            SEL_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SEL_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicates right-justified store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                                input logic [2:0]  sel);
        logic [31:0] r;
        case (sel)
            SEL_BYTE: r = {4{wdata[7:0]}};
            SEL_HALF: r = {2{wdata[15:0]}};
            default:  r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side data port plus console drain port of the data-memory stage.
// master = CPU core / console consumer side, slave = dmem_ctrl.
interface dmem_if;
    import dmem_pkg::*;

    logic        cs;
    logic        dm_r;
    logic        dm_w;
    logic [2:0]  select;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        err;

    modport master (
        output cs, dm_r, dm_w, select, addr, wdata, out_ready,
        input  rdata, out_valid, out_data, err
    );

    modport slave (
        input  cs, dm_r, dm_w, select, addr, wdata, out_ready,
        output rdata, out_valid, out_data, err
    );

endinterface

// File: rtl/dmem_fifo.sv
// Small synchronous FIFO (power-of-2 depth) used for the console TX queue.
// A push while full is accepted only if a pop happens in the same cycle.
module dmem_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {(PW+1){1'b0}});
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Next pointer and occupancy from accepted push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy guards them.
    always_ff @(posedge clk_in) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage behind the single-cycle core: word RAM with big-endian
// byte lanes, alignment/decode error tracking, and an MMIO block holding the
// console TX FIFO, STATUS and a free-running CYCLE counter.
// Optional build macro DMEM_STATS_EN adds LOADS/STORES counters at MMIO
// offsets 0xC and 0x10; without it those offsets are unmapped.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic  clk_in,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;
`ifdef DMEM_STATS_EN
    localparam logic [31:0] MMIO_BYTES = 32'h0000_0014;
`else
    localparam logic [31:0] MMIO_BYTES = 32'h0000_0010;
`endif

    // Access qualification and address decode
    logic            wr_s, rd_s, acc_s;
    logic [31:0]     ram_off_s, mmio_off_s;
    logic            in_ram_s, in_mmio_s;
    logic [AW-1:0]   ram_idx_s;
    logic [31:0]     ram_word_s;
    logic            size_ok_s, ram_ok_s, mmio_ok_s, fault_s;
    mmio_reg_e       mmio_reg_s;
    logic [3:0]      be_s;
    logic [31:0]     wlane_s;
    logic            ram_we_s, mmio_we_s;
    logic            tx_push_s, st_wr_s, cyc_wr_s;
    logic [31:0]     rdata_s, status_s;

    // Storage and MMIO state
    logic [31:0]     mem_q [DEPTH];
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     cycle_q, cycle_d;

    // Console FIFO
    logic            pop_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [7:0]      fifo_head_s;

    assign wr_s  = bus.cs & bus.dm_w;
    assign rd_s  = bus.cs & bus.dm_r & ~bus.dm_w;
    assign acc_s = wr_s | rd_s;

    assign ram_off_s  = bus.addr - RAM_BASE;
    assign mmio_off_s = bus.addr - MMIO_BASE;
    assign in_ram_s   = (ram_off_s < RAM_BYTES);
    assign in_mmio_s  = (mmio_off_s < MMIO_BYTES);
    assign ram_idx_s  = ram_off_s[AW+1:2];
    assign ram_word_s = mem_q[ram_idx_s];

    // Select the MMIO register addressed by the low offset bits.
    always_comb begin
        mmio_reg_s = REG_NONE;
        if (in_mmio_s) begin
            case (mmio_off_s[4:0])
                OFF_TX:     mmio_reg_s = REG_TX;
                OFF_STATUS: mmio_reg_s = REG_STATUS;
                OFF_CYCLE:  mmio_reg_s = REG_CYCLE;
`ifdef DMEM_STATS_EN
                OFF_LOADS:  mmio_reg_s = REG_LOADS;
                OFF_STORES: mmio_reg_s = REG_STORES;
`else
                OFF_LOADS:  mmio_reg_s = REG_NONE;
                OFF_STORES: mmio_reg_s = REG_NONE;
`endif
                default:    mmio_reg_s = REG_NONE;
            endcase
        end else begin
            mmio_reg_s = REG_NONE;
        end
    end

    // A bad size, misalignment, unmapped address or non-word MMIO access
    // suppresses the access and raises the sticky error.
    assign size_ok_s = sel_onehot(bus.select) & ~misaligned(bus.select, bus.addr[1:0]);
    assign ram_ok_s  = size_ok_s & in_ram_s;
    assign mmio_ok_s = size_ok_s & (bus.select == SEL_WORD) & (mmio_reg_s != REG_NONE);
    assign fault_s   = acc_s & ~(ram_ok_s | mmio_ok_s);

    assign be_s      = byte_enables(bus.select, bus.addr[1:0]);
    assign wlane_s   = store_lanes(bus.wdata, bus.select);
    assign ram_we_s  = wr_s & ram_ok_s;
    assign mmio_we_s = wr_s & mmio_ok_s;
    assign tx_push_s = mmio_we_s & (mmio_reg_s == REG_TX);
    assign st_wr_s   = mmio_we_s & (mmio_reg_s == REG_STATUS);
    assign cyc_wr_s  = mmio_we_s & (mmio_reg_s == REG_CYCLE);

    assign pop_s = ~fifo_empty_s & bus.out_ready;

    dmem_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push_i  (tx_push_s),
        .data_i  (bus.wdata[7:0]),
        .pop_i   (pop_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s),
        .head_o  (fifo_head_s)
    );

`ifdef DMEM_STATS_EN
    logic        ld_wr_s, sc_wr_s;
    logic [31:0] loads_q, loads_d;
    logic [31:0] stores_q, stores_d;

    assign ld_wr_s = mmio_we_s & (mmio_reg_s == REG_LOADS);
    assign sc_wr_s = mmio_we_s & (mmio_reg_s == REG_STORES);

    // Count successful RAM loads/stores; a write to a counter clears it.
    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        if (ld_wr_s) begin
            loads_d = 32'h0000_0000;
        end else if (rd_s && ram_ok_s) begin
            loads_d = loads_q + 32'd1;
        end else begin
            loads_d = loads_q;
        end
        if (sc_wr_s) begin
            stores_d = 32'h0000_0000;
        end else if (ram_we_s) begin
            stores_d = stores_q + 32'd1;
        end else begin
            stores_d = stores_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            loads_q  <= 32'h0000_0000;
            stores_q <= 32'h0000_0000;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
        end
    end
`endif

    // Assemble the STATUS read value from live flags and FIFO occupancy.
    always_comb begin
        status_s           = 32'h0000_0000;
        status_s[ST_EMPTY] = fifo_empty_s;
        status_s[ST_FULL]  = fifo_full_s;
        status_s[ST_OVF]   = ovf_q;
        status_s[ST_ERR]   = err_q;
        status_s[15:8]     = 8'(fifo_count_s);
    end

    // Load data: RAM lanes or MMIO register, zero when idle or suppressed.
    // Gated on dm_r alone so a combined read/write still shows the old value.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (bus.cs && bus.dm_r && ram_ok_s) begin
            rdata_s = load_lanes(ram_word_s, bus.select, bus.addr[1:0]);
        end else if (bus.cs && bus.dm_r && mmio_ok_s) begin
            case (mmio_reg_s)
                REG_STATUS: rdata_s = status_s;
                REG_CYCLE:  rdata_s = cycle_q;
`ifdef DMEM_STATS_EN
                REG_LOADS:  rdata_s = loads_q;
                REG_STORES: rdata_s = stores_q;
`endif
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Sticky flags with write-one-to-clear (a new set event wins) and the
    // cycle counter (a software load wins over the increment).
    always_comb begin
        err_d   = err_q;
        ovf_d   = ovf_q;
        cycle_d = cycle_q + 32'd1;
        if (fault_s) begin
            err_d = 1'b1;
        end else if (st_wr_s && bus.wdata[ST_ERR]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (tx_push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (st_wr_s && bus.wdata[ST_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (cyc_wr_s) begin
            cycle_d = bus.wdata;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    // MMIO state registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cycle_q <= 32'h0000_0000;
        end else begin
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // Data RAM with per-lane write enables; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[ram_idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.rdata     = rdata_s;
    assign bus.out_valid = ~fifo_empty_s;
    assign bus.out_data  = fifo_head_s;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl. The driver pushes each expected response
// into a scoreboard queue; a negedge monitor pops and compares whenever a
// probe is presented or the console port transfers a byte.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam logic [31:0] RAM0    = 32'h1001_0000;
    localparam logic [31:0] RAMLAST = 32'h1001_0FFC;
    localparam logic [31:0] M_TX    = 32'hFFFF_0000;
    localparam logic [31:0] M_ST    = 32'hFFFF_0004;
    localparam logic [31:0] M_CYC   = 32'hFFFF_0008;

    localparam int K_RDATA = 0;
    localparam int K_ERR   = 1;
    localparam int K_OUTV  = 2;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    int errors = 0;
    int checks = 0;

    int          exp_kind_q [$];
    logic [31:0] exp_val_q  [$];
    string       exp_name_q [$];
    logic [7:0]  stream_q   [$];
    logic        probe_en = 1'b0;

    int          mk;
    logic [31:0] mv, mact;
    string       mn;
    logic [7:0]  me;

    dmem_if bus_if ();

    dmem_ctrl dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus_if)
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard monitor: probes and console transfers, sampled at negedge.
    always @(negedge clk_in) begin
        if (probe_en) begin
            checks = checks + 1;
            if (exp_val_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_underflow: got probe, required queued expectation");
            end else begin
                mk = exp_kind_q.pop_front();
                mv = exp_val_q.pop_front();
                mn = exp_name_q.pop_front();
                case (mk)
                    K_RDATA: mact = bus_if.rdata;
                    K_ERR:   mact = {31'd0, bus_if.err};
                    default: mact = {31'd0, bus_if.out_valid};
                endcase
                if (mact !== mv) begin
                    errors = errors + 1;
                    $display("FAIL %s: got 0x%08h required 0x%08h", mn, mact, mv);
                end
            end
        end
        if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            checks = checks + 1;
            if (stream_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL console_unexpected: got byte 0x%02h, required none", bus_if.out_data);
            end else begin
                me = stream_q.pop_front();
                if (bus_if.out_data !== me) begin
                    errors = errors + 1;
                    $display("FAIL console_byte: got 0x%02h required 0x%02h", bus_if.out_data, me);
                end
            end
        end
    end

    task automatic bus_idle();
        bus_if.cs     = 1'b0;
        bus_if.dm_r   = 1'b0;
        bus_if.dm_w   = 1'b0;
        bus_if.select = SEL_WORD;
        bus_if.addr   = 32'h0000_0000;
        bus_if.wdata  = 32'h0000_0000;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        bus_if.cs     = 1'b1;
        bus_if.dm_w   = 1'b1;
        bus_if.dm_r   = 1'b0;
        bus_if.select = s;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] e, input string n);
        bus_if.cs     = 1'b1;
        bus_if.dm_r   = 1'b1;
        bus_if.dm_w   = 1'b0;
        bus_if.select = s;
        bus_if.addr   = a;
        exp_kind_q.push_back(K_RDATA);
        exp_val_q.push_back(e);
        exp_name_q.push_back(n);
        probe_en = 1'b1;
        tick();
        probe_en = 1'b0;
        bus_idle();
    endtask

    task automatic chk_flag(input int k, input logic e, input string n);
        exp_kind_q.push_back(k);
        exp_val_q.push_back({31'd0, e});
        exp_name_q.push_back(n);
        probe_en = 1'b1;
        tick();
        probe_en = 1'b0;
    endtask

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        do_read(M_CYC, SEL_WORD, 32'h0000_0000, "reset_cycle");
        chk_flag(K_ERR, 1'b0, "reset_err");
        chk_flag(K_OUTV, 1'b0, "reset_out_valid");
        do_read(M_ST, SEL_WORD, 32'h0000_0001, "reset_status");

        // Lane placement
        do_write(RAM0, 32'hAABB_CCDD, SEL_WORD);
        do_read(RAM0 + 32'd1, SEL_BYTE, 32'hBBCC_DD00, "lb_off1");
        do_read(RAM0 + 32'd2, SEL_HALF, 32'hCCDD_0000, "lh_off2");
        do_read(RAM0, SEL_WORD, 32'hAABB_CCDD, "lw_word");

        // Byte write
        do_write(RAM0 + 32'd2, 32'h0000_0011, SEL_BYTE);
        do_read(RAM0, SEL_WORD, 32'hAABB_11DD, "sb_merge");
        chk_flag(K_ERR, 1'b0, "sb_no_err");

        // Last RAM word
        do_write(RAMLAST, 32'h1234_5678, SEL_WORD);
        do_read(RAMLAST, SEL_WORD, 32'h1234_5678, "last_word");
        do_read(RAMLAST + 32'd3, SEL_BYTE, 32'h7800_0000, "last_byte");
        chk_flag(K_ERR, 1'b0, "last_no_err");

        // Misaligned store suppressed, W1C of err
        do_write(RAM0 + 32'd1, 32'h0000_FFFF, SEL_HALF);
        chk_flag(K_ERR, 1'b1, "misalign_err");
        do_read(M_ST, SEL_WORD, 32'h0000_0009, "status_err");
        do_read(RAM0, SEL_WORD, 32'hAABB_11DD, "misalign_no_write");
        do_write(M_ST, 32'h0000_0008, SEL_WORD);
        chk_flag(K_ERR, 1'b0, "err_cleared");

        // Misaligned word read returns zero
        do_read(RAM0 + 32'd2, SEL_WORD, 32'h0000_0000, "misalign_rdata");
        chk_flag(K_ERR, 1'b1, "misalign_rd_err");
        do_write(M_ST, 32'h0000_0008, SEL_WORD);

        // Just past the RAM is unmapped
        do_read(RAM0 + 32'h0000_1000, SEL_WORD, 32'h0000_0000, "unmapped_rdata");
        chk_flag(K_ERR, 1'b1, "unmapped_err");
        do_write(M_ST, 32'h0000_0008, SEL_WORD);

        // Non-word MMIO access
        do_read(M_ST, SEL_BYTE, 32'h0000_0000, "mmio_byte_rdata");
        chk_flag(K_ERR, 1'b1, "mmio_byte_err");
        do_write(M_ST, 32'h0000_0008, SEL_WORD);
        chk_flag(K_ERR, 1'b0, "err_cleared2");

`ifndef DMEM_STATS_EN
        // Offset 0xC has no register in the default build
        do_read(32'hFFFF_000C, SEL_WORD, 32'h0000_0000, "off_c_rdata");
        chk_flag(K_ERR, 1'b1, "off_c_err");
        do_write(M_ST, 32'h0000_0008, SEL_WORD);
`endif

        // Cycle counter load and wrap
        do_write(M_CYC, 32'hFFFF_FFFE, SEL_WORD);
        do_read(M_CYC, SEL_WORD, 32'hFFFF_FFFE, "cycle_t1");
        do_read(M_CYC, SEL_WORD, 32'hFFFF_FFFF, "cycle_t2");
        do_read(M_CYC, SEL_WORD, 32'h0000_0000, "cycle_wrap");

        // FIFO fill and overflow
        bus_if.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) stream_q.push_back(8'(i));
            do_write(M_TX, 32'(i), SEL_WORD);
        end
        do_read(M_ST, SEL_WORD, 32'h0000_0806, "status_full_ovf");
        chk_flag(K_ERR, 1'b0, "ovf_no_err");
        do_write(M_ST, 32'h0000_0004, SEL_WORD);
        do_read(M_ST, SEL_WORD, 32'h0000_0802, "ovf_cleared");

        // Push and pop together while full
        bus_if.out_ready = 1'b1;
        stream_q.push_back(8'h0A);
        do_write(M_TX, 32'h0000_000A, SEL_WORD);
        bus_if.out_ready = 1'b0;
        do_read(M_ST, SEL_WORD, 32'h0000_0802, "push_pop_full");

        // Drain
        bus_if.out_ready = 1'b1;
        repeat (8) tick();
        chk_flag(K_OUTV, 1'b0, "drained_out_valid");
        do_read(M_ST, SEL_WORD, 32'h0000_0001, "drained_status");

        // Reset in the middle of a drain
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            stream_q.push_back(8'h21 + 8'(i));
            do_write(M_TX, 32'h21 + 32'(i), SEL_WORD);
        end
        bus_if.out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stream_q.delete();
        do_read(M_ST, SEL_WORD, 32'h0000_0001, "post_reset_status");
        do_read(M_CYC, SEL_WORD, 32'h0000_0001, "post_reset_cycle");
        chk_flag(K_OUTV, 1'b0, "post_reset_out_valid");
        do_read(RAM0, SEL_WORD, 32'hAABB_11DD, "ram_survives_reset");
        bus_if.out_ready = 1'b0;
        tick();
        tick();

        checks = checks + 1;
        if (stream_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL console_leftover: got %0d pending bytes, required 0", stream_q.size());
        end
        checks = checks + 1;
        if (exp_val_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_val_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
